// File: rtl/pilsr_pkg.sv
// rtl/pilsr_pkg.sv - shared types and constants for the pilsr serial link
package pilsr_pkg;

    // Word length shared by the pilsr transmitter and the pilsr_rx receiver.
    localparam int PILSR_WIDTH = 4;

    // Receiver FSM: IDLE while the bit count is 0, RECV while a word is partly received.
    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    // Width of a bit counter that runs 0..width-1.
    function automatic int cntWidth(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/pilsr_rx_shift.sv
// rtl/pilsr_rx_shift.sv - MSB-first shift register and bit counter for pilsr_rx
//
// Ports:
//   c         clock, rising edge
//   r         asynchronous active-low reset
//   shiftEn   strobe: sample shiftIn on this edge
//   shiftIn   serial data bit (MSB of a word first)
//   clear     synchronous abort of the partial word, overrides shiftEn
//   partial   registered shift-register contents
//   busy      registered: a partial word is in progress
//   wordDone  combinational: this edge samples the last bit of a word
//   wordData  combinational: the word completed on this edge
module pilsr_rx_shift
    import pilsr_pkg::*;
#(
    parameter int WIDTH = PILSR_WIDTH
) (
    input  logic             c,
    input  logic             r,
    input  logic             shiftEn,
    input  logic             shiftIn,
    input  logic             clear,
    output logic [WIDTH-1:0] partial,
    output logic             busy,
    output logic             wordDone,
    output logic [WIDTH-1:0] wordData
);

    localparam int CW = cntWidth(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    rx_state_t        state;
    rx_state_t        stateNext;
    logic [CW-1:0]    count;
    logic [CW-1:0]    countNext;
    logic [WIDTH-1:0] shiftReg;
    logic [WIDTH-1:0] shiftNext;
    logic [WIDTH-1:0] shifted;

    assign shifted  = {shiftReg[WIDTH-2:0], shiftIn};
    assign wordData = shifted;
    assign partial  = shiftReg;
    assign busy     = (state == RECV);

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            state    <= IDLE;
            count    <= '0;
            shiftReg <= '0;
        end else begin
            state    <= stateNext;
            count    <= countNext;
            shiftReg <= shiftNext;
        end
    end

    always_comb begin
        stateNext = state;
        countNext = count;
        shiftNext = shiftReg;
        wordDone  = 1'b0;
        if (clear) begin
            stateNext = IDLE;
            countNext = '0;
            shiftNext = '0;
        end else if (shiftEn) begin
            case (state)
                IDLE: begin
                    // WIDTH >= 2, so the first bit never completes a word.
                    stateNext = RECV;
                    countNext = CW'(1);
                    shiftNext = shifted;
                end
                RECV: begin
                    if (count == LAST) begin
                        // Word complete: hand it up and restart from an empty register.
                        wordDone  = 1'b1;
                        stateNext = IDLE;
                        countNext = '0;
                        shiftNext = '0;
                    end else begin
                        countNext = count + CW'(1);
                        shiftNext = shifted;
                    end
                end
                default: begin
                    stateNext = IDLE;
                    countNext = '0;
                    shiftNext = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pilsr_rx.sv
// rtl/pilsr_rx.sv - serial-in parallel-out receiver for the pilsr stream
//
// Ports:
//   c          clock, rising edge
//   r          asynchronous active-low reset
//   shiftEn    serial bit strobe
//   shiftIn    serial data bit, MSB first
//   clear      synchronous abort of the partial word; clears overrun
//   wordReady  consumer accepts wordOut this cycle
//   wordOut    last completed word (holding register)
//   wordValid  wordOut holds an unconsumed word
//   overrun    sticky: a completed word was dropped
//   busy       a partial word is in progress
//   partial    live shift-register contents
module pilsr_rx
    import pilsr_pkg::*;
#(
    parameter int WIDTH = PILSR_WIDTH
) (
    input  logic             c,
    input  logic             r,
    input  logic             shiftEn,
    input  logic             shiftIn,
    input  logic             clear,
    input  logic             wordReady,
    output logic [WIDTH-1:0] wordOut,
    output logic             wordValid,
    output logic             overrun,
    output logic             busy,
    output logic [WIDTH-1:0] partial
);

    logic             wordDone;
    logic [WIDTH-1:0] wordData;
    logic             holdFree;

    pilsr_rx_shift #(
        .WIDTH(WIDTH)
    ) u_shift (
        .c        (c),
        .r        (r),
        .shiftEn  (shiftEn),
        .shiftIn  (shiftIn),
        .clear    (clear),
        .partial  (partial),
        .busy     (busy),
        .wordDone (wordDone),
        .wordData (wordData)
    );

    // A pending word being consumed this cycle frees the slot for a word completing on the same edge.
    assign holdFree = !wordValid || wordReady;

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            wordOut   <= '0;
            wordValid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (wordDone && holdFree) begin
                wordOut   <= wordData;
                wordValid <= 1'b1;
            end else if (wordValid && wordReady) begin
                wordValid <= 1'b0;
            end

            // clear suppresses wordDone, so the two never collide here.
            if (clear) begin
                overrun <= 1'b0;
            end else if (wordDone && !holdFree) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pilsr_rx.sv
// tb/tb_pilsr_rx.sv - self-checking bench for pilsr_rx
module tb_pilsr_rx;

    localparam int W = 4;

    logic         c;
    logic         r;
    logic         shiftEn;
    logic         shiftIn;
    logic         clear;
    logic         wordReady;
    logic [W-1:0] wordOut;
    logic         wordValid;
    logic         overrun;
    logic         busy;
    logic [W-1:0] partial;

    int checks = 0;
    int errors = 0;

    pilsr_rx #(.WIDTH(W)) dut (
        .c         (c),
        .r         (r),
        .shiftEn   (shiftEn),
        .shiftIn   (shiftIn),
        .clear     (clear),
        .wordReady (wordReady),
        .wordOut   (wordOut),
        .wordValid (wordValid),
        .overrun   (overrun),
        .busy      (busy),
        .partial   (partial)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    typedef struct {
        logic         en;
        logic         bitIn;
        logic         clr;
        logic         rdy;
        logic [W-1:0] wo;
        logic         wv;
        logic         ov;
        logic         bsy;
        logic [W-1:0] part;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: bits received so far, as a running number.
    int mCnt;
    int mAcc;
    int mHold;
    bit mHv;
    bit mOv;

    function automatic logic [2*W+2:0] packOut(input logic [W-1:0] wo, input logic wv,
                                               input logic ov, input logic bsy,
                                               input logic [W-1:0] part);
        return {wo, wv, ov, bsy, part};
    endfunction

    task automatic chk(input string name, input logic [2*W+2:0] act, input logic [2*W+2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got wo/wv/ov/busy/part=%b required %b", name, act, exp);
        end
    endtask

    task automatic addV(input logic en, input logic bitIn, input logic clr, input logic rdy,
                        input int wo, input logic wv, input logic ov, input logic bsy,
                        input int part);
        vec_t v;
        v.en = en; v.bitIn = bitIn; v.clr = clr; v.rdy = rdy;
        v.wo = W'(wo); v.wv = wv; v.ov = ov; v.bsy = bsy; v.part = W'(part);
        vecs.push_back(v);
    endtask

    task automatic drive(input logic en, input logic bitIn, input logic clr, input logic rdy);
        shiftEn = en; shiftIn = bitIn; clear = clr; wordReady = rdy;
    endtask

    task automatic stepEdge();
        @(posedge c);
        #1;
    endtask

    task automatic modelStep(input bit en, input bit bitIn, input bit clr, input bit rdy);
        bit done;
        int word;
        done = 0;
        word = 0;
        if (clr) begin
            mCnt = 0; mAcc = 0; mOv = 0;
        end else if (en) begin
            mAcc = (mAcc * 2 + int'(bitIn)) % (1 << W);
            mCnt++;
            if (mCnt == W) begin
                done = 1; word = mAcc; mCnt = 0; mAcc = 0;
            end
        end
        if (done && (!mHv || rdy)) begin
            mHold = word; mHv = 1;
        end else begin
            if (done) mOv = 1;
            if (mHv && rdy) mHv = 0;
        end
    endtask

    initial begin
        r = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) stepEdge();
        chk("reset_state", packOut(wordOut, wordValid, overrun, busy, partial), '0);
        r = 1'b1;

        // en, bit, clr, rdy, wo, wv, ov, busy, partial
        // bits 0,1,1,1 -> 7
        addV(1,0,0,0,  0,0,0,1,0);
        addV(1,1,0,0,  0,0,0,1,1);
        addV(1,1,0,0,  0,0,0,1,3);
        addV(1,1,0,0,  7,1,0,0,0);
        addV(0,0,0,1,  7,0,0,0,0);
        // gapped 1,0, three idles, 1,1 -> 11
        addV(1,1,0,0,  7,0,0,1,1);
        addV(1,0,0,0,  7,0,0,1,2);
        addV(0,0,0,0,  7,0,0,1,2);
        addV(0,1,0,0,  7,0,0,1,2);
        addV(0,0,0,0,  7,0,0,1,2);
        addV(1,1,0,0,  7,0,0,1,5);
        addV(1,1,0,0, 11,1,0,0,0);
        // back-to-back 0100, 0101 with wordReady held
        addV(1,0,0,1, 11,0,0,1,0);
        addV(1,1,0,1, 11,0,0,1,1);
        addV(1,0,0,1, 11,0,0,1,2);
        addV(1,0,0,1,  4,1,0,0,0);
        addV(1,0,0,1,  4,0,0,1,0);
        addV(1,1,0,1,  4,0,0,1,1);
        addV(1,0,0,1,  4,0,0,1,2);
        addV(1,1,0,1,  5,1,0,0,0);
        // overrun: 14 pending, 6 dropped
        addV(0,0,0,1,  5,0,0,0,0);
        addV(1,1,0,0,  5,0,0,1,1);
        addV(1,1,0,0,  5,0,0,1,3);
        addV(1,1,0,0,  5,0,0,1,7);
        addV(1,0,0,0, 14,1,0,0,0);
        addV(1,0,0,0, 14,1,0,1,0);
        addV(1,1,0,0, 14,1,0,1,1);
        addV(1,1,0,0, 14,1,0,1,3);
        addV(1,0,0,0, 14,1,1,0,0);
        addV(0,0,0,1, 14,0,1,0,0);
        addV(0,0,0,0, 14,0,1,0,0);
        // clear with shiftEn after two bits, then 1,1,0,1 -> 13
        addV(1,1,0,0, 14,0,1,1,1);
        addV(1,0,0,0, 14,0,1,1,2);
        addV(1,1,1,0, 14,0,0,0,0);
        addV(1,1,0,0, 14,0,0,1,1);
        addV(1,1,0,0, 14,0,0,1,3);
        addV(1,0,0,0, 14,0,0,1,6);
        addV(1,1,0,0, 13,1,0,0,0);
        // 12 pending, 9 completes on the same edge it is consumed
        addV(0,0,0,1, 13,0,0,0,0);
        addV(1,1,0,0, 13,0,0,1,1);
        addV(1,1,0,0, 13,0,0,1,3);
        addV(1,0,0,0, 13,0,0,1,6);
        addV(1,0,0,0, 12,1,0,0,0);
        addV(1,1,0,0, 12,1,0,1,1);
        addV(1,0,0,0, 12,1,0,1,2);
        addV(1,0,0,0, 12,1,0,1,4);
        addV(1,1,0,1,  9,1,0,0,0);
        addV(0,0,0,1,  9,0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].bitIn, vecs[i].clr, vecs[i].rdy);
            stepEdge();
            chk($sformatf("vec%0d", i), packOut(wordOut, wordValid, overrun, busy, partial),
                packOut(vecs[i].wo, vecs[i].wv, vecs[i].ov, vecs[i].bsy, vecs[i].part));
        end

        // Reset mid-word with a pending word: everything drops to 0 at once.
        drive(1, 1, 0, 0);
        repeat (4) stepEdge();
        drive(1, 1, 0, 0);
        repeat (2) stepEdge();
        r = 1'b0;
        #1;
        chk("async_reset_midword", packOut(wordOut, wordValid, overrun, busy, partial), '0);
        stepEdge();
        chk("held_in_reset", packOut(wordOut, wordValid, overrun, busy, partial), '0);
        r = 1'b1;
        drive(1, 0, 0, 0); stepEdge();
        drive(1, 1, 0, 0); stepEdge();
        drive(1, 1, 0, 0); stepEdge();
        chk("post_reset_3bits", packOut(wordOut, wordValid, overrun, busy, partial),
            packOut(0, 0, 0, 1, 3));
        drive(1, 1, 0, 0); stepEdge();
        chk("post_reset_word7", packOut(wordOut, wordValid, overrun, busy, partial),
            packOut(7, 1, 0, 0, 0));

        // Randomized run against the reference model.
        r = 1'b0;
        drive(0, 0, 0, 0);
        stepEdge();
        r = 1'b1;
        mCnt = 0; mAcc = 0; mHold = 0; mHv = 0; mOv = 0;
        for (int i = 0; i < 600; i++) begin
            logic en, b, clr, rdy;
            en  = ($urandom_range(0, 9) < 7);
            b   = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 23) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            drive(en, b, clr, rdy);
            modelStep(en, b, clr, rdy);
            stepEdge();
            chk($sformatf("rand%0d", i), packOut(wordOut, wordValid, overrun, busy, partial),
                packOut(W'(mHold), mHv, mOv, mCnt != 0, W'(mAcc)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
